// File: rtl/mdr_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mdr_unit_arbiter
//  Purpose  : Round-robin arbiter and sequencer for a shared MDR arithmetic
//             unit behind a 4:1 operand mux. It grants one requester, pulses
//             start, holds the mux select until done or a watchdog abort, and
//             returns a per-requester completion acknowledge.
//  Revision : 1.0 - initial release
// ============================================================================
module mdr_unit_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW_SEL  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_done,
    output logic [DW_SEL-1:0] o_sel,
    output logic [N_REQ-1:0]  o_gnt,
    output logic              o_start,
    output logic              o_busy,
    output logic [N_REQ-1:0]  o_ack,
    output logic              o_timeout
);

    // Watchdog width leaves headroom so the count never wraps in a transaction
    localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DW_SEL-1:0]   r_ptr;
    logic [DW_SEL-1:0]   w_ptr_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [DW_SEL-1:0]   w_sel_nxt;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic                w_start_nxt;
    logic                w_busy_nxt;
    logic [N_REQ-1:0]    w_ack_nxt;
    logic                w_timeout_nxt;

    logic                w_found;
    logic [DW_SEL-1:0]   w_idx;
    logic [DW_SEL-1:0]   w_cand;

    // Rotating priority scan starting at the pointer; the select width is
    // exactly log2(N_REQ), so plain addition wraps modulo the requester count
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = r_ptr + DW_SEL'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Next-state and next-output decode; outputs are held unless changed here
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = o_sel;
        w_gnt_nxt     = o_gnt;
        w_start_nxt   = 1'b0;
        w_busy_nxt    = o_busy;
        w_ack_nxt     = '0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = N_REQ'(1) << w_idx;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // done is deliberately ignored here: the unit has not started
                w_cnt_nxt   = '0;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (i_done) begin
                    // done has precedence over a watchdog expiry in the same cycle
                    w_ack_nxt   = N_REQ'(1) << o_sel;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = o_sel + DW_SEL'(1);
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = o_sel + DW_SEL'(1);
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pointer, watchdog and registered outputs with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            o_sel     <= '0;
            o_gnt     <= '0;
            o_start   <= 1'b0;
            o_busy    <= 1'b0;
            o_ack     <= '0;
            o_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            o_sel     <= w_sel_nxt;
            o_gnt     <= w_gnt_nxt;
            o_start   <= w_start_nxt;
            o_busy    <= w_busy_nxt;
            o_ack     <= w_ack_nxt;
            o_timeout <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire
